// File: rtl/mcn_tag_sender.sv
// Multicast-network transmit side: loads a cluster's ID scan chain, then streams tagged GLB words.
// Optional stall counter is built when MCN_TX_STALL_CNT_EN is defined.
module mcn_tag_sender #(
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int numPeX   = 14,
  parameter int numPeY   = 3
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                id_wr_en_i,
  input  logic [5:0]          id_wr_addr_i,
  input  logic [idSize-1:0]   id_wr_data_i,
  input  logic                scan_start_i,
  input  logic                stream_start_i,
  input  logic [15:0]         stream_len_i,
  input  logic [dataSize-1:0] in_data_i,
  input  logic [idSize-1:0]   in_tag_x_i,
  input  logic [idSize-1:0]   in_tag_y_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [dataSize-1:0] data_o,
  output logic [idSize-1:0]   tag_x_o,
  output logic [idSize-1:0]   tag_y_o,
  output logic [idSize-1:0]   id_scan_o,
  output logic                id_wren_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         stall_cnt_o
);

  localparam int numIds = numPeX * numPeY + numPeY;
  localparam logic [idSize-1:0] NULL_TAG = {idSize{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WREN, S_STREAM} state_t;

  state_t            state;
  logic [idSize-1:0] id_table [numIds];
  logic [15:0]       cnt;
  logic [15:0]       last_idx;
  logic              accept;
  logic              stream_go;

  assign in_ready_o = (state == S_STREAM);
  assign busy_o     = (state != S_IDLE);
  assign accept     = in_valid_i && in_ready_o;
  assign stream_go  = (state == S_IDLE) && !scan_start_i && stream_start_i && (stream_len_i != 16'd0);

  // Table is frozen while the chain is being shifted or written.
  always_ff @(posedge clk) begin
    if (id_wr_en_i && (state == S_IDLE || state == S_STREAM) && (id_wr_addr_i < 6'(numIds)))
      id_table[id_wr_addr_i] <= id_wr_data_i;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      last_idx  <= '0;
      data_o    <= '0;
      tag_x_o   <= NULL_TAG;
      tag_y_o   <= NULL_TAG;
      id_scan_o <= '0;
      id_wren_o <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      id_wren_o <= 1'b0;
      case (state)
        S_IDLE: begin
          tag_x_o   <= NULL_TAG;
          tag_y_o   <= NULL_TAG;
          id_scan_o <= '0;
          if (scan_start_i) begin
            // Entry 0 goes out with the transition; cnt then holds the next index.
            state     <= S_SCAN;
            id_scan_o <= id_table[0];
            cnt       <= 16'd1;
          end else if (stream_start_i) begin
            if (stream_len_i == 16'd0) begin
              done_o <= 1'b1;
            end else begin
              state    <= S_STREAM;
              cnt      <= '0;
              last_idx <= stream_len_i - 16'd1;
            end
          end
        end
        S_SCAN: begin
          if (cnt == 16'(numIds)) begin
            id_scan_o <= '0;
            id_wren_o <= 1'b1;
            state     <= S_WREN;
          end else begin
            id_scan_o <= id_table[cnt[5:0]];
            cnt       <= cnt + 16'd1;
          end
        end
        S_WREN: begin
          state  <= S_IDLE;
          done_o <= 1'b1;
        end
        S_STREAM: begin
          if (accept) begin
            data_o  <= in_data_i;
            tag_x_o <= in_tag_x_i;
            tag_y_o <= in_tag_y_i;
            cnt     <= cnt + 16'd1;
            if (cnt == last_idx) begin
              state  <= S_IDLE;
              done_o <= 1'b1;
            end
          end else begin
            tag_x_o <= NULL_TAG;
            tag_y_o <= NULL_TAG;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MCN_TX_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)
      stall_cnt <= '0;
    else if (stream_go)
      stall_cnt <= '0;
    else if (state == S_STREAM && !in_valid_i && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mcn_tag_sender.sv
// Scoreboard bench for mcn_tag_sender: stimulus pushes expected bus/scan events, a negedge monitor pops them.
module tb_mcn_tag_sender;

  logic        clk = 1'b0;
  logic        nrst;
  logic        id_wr_en;
  logic [5:0]  id_wr_addr;
  logic [7:0]  id_wr_data;
  logic        scan_start, stream_start;
  logic [15:0] stream_len;
  logic [7:0]  in_data, in_tag_x, in_tag_y;
  logic        in_valid, in_ready;
  logic [7:0]  data, tag_x, tag_y, id_scan;
  logic        id_wren, busy, done;
  logic [15:0] stall_cnt;

  mcn_tag_sender dut (
    .clk(clk), .nrst(nrst),
    .id_wr_en_i(id_wr_en), .id_wr_addr_i(id_wr_addr), .id_wr_data_i(id_wr_data),
    .scan_start_i(scan_start), .stream_start_i(stream_start), .stream_len_i(stream_len),
    .in_data_i(in_data), .in_tag_x_i(in_tag_x), .in_tag_y_i(in_tag_y),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .data_o(data), .tag_x_o(tag_x), .tag_y_o(tag_y), .id_scan_o(id_scan),
    .id_wren_o(id_wren), .busy_o(busy), .done_o(done), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data, tx, ty, scan;
    logic       wren, done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] hold_data = 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [7:0] d, input logic [7:0] x, input logic [7:0] y, input logic dn);
    q.push_back('{data: d, tx: x, ty: y, scan: 8'h00, wren: 1'b0, done: dn});
    hold_data = d;
  endtask

  task automatic push_idle(input logic [7:0] sc, input logic wr, input logic dn);
    q.push_back('{data: hold_data, tx: 8'hFF, ty: 8'hFF, scan: sc, wren: wr, done: dn});
  endtask

  // Monitor: any non-idle output cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (nrst === 1'b1 && (tag_x != 8'hFF || tag_y != 8'hFF || done || id_wren || id_scan != 8'h00)) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: data=%h x=%h y=%h scan=%h wren=%b done=%b",
                 data, tag_x, tag_y, id_scan, id_wren, done);
      end else begin
        e = q.pop_front();
        if (data !== e.data || tag_x !== e.tx || tag_y !== e.ty || id_scan !== e.scan ||
            id_wren !== e.wren || done !== e.done) begin
          n_bad++;
          $display("FAIL bus_event: got d=%h x=%h y=%h s=%h w=%b dn=%b expected d=%h x=%h y=%h s=%h w=%b dn=%b",
                   data, tag_x, tag_y, id_scan, id_wren, done,
                   e.data, e.tx, e.ty, e.scan, e.wren, e.done);
        end
      end
    end
  end

  initial begin
    logic [7:0]  wd [4];
    logic        gap_v [5];
    logic [7:0]  gap_d [3];
    logic [7:0]  gap_x [3];
    logic [7:0]  gap_y [3];
    logic [15:0] exp_stall;
    int          gi;

    nrst = 1'b0; id_wr_en = 0; id_wr_addr = 0; id_wr_data = 0;
    scan_start = 0; stream_start = 0; stream_len = 0;
    in_data = 0; in_tag_x = 0; in_tag_y = 0; in_valid = 0;
    repeat (3) tick();

    check("rst_tag_x", 16'(tag_x), 16'h00FF);
    check("rst_tag_y", 16'(tag_y), 16'h00FF);
    check("rst_wren", 16'(id_wren), 16'h0);
    check("rst_ready", 16'(in_ready), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_data", 16'(data), 16'h0);

    nrst = 1'b1;
    tick();

    for (int k = 0; k < 45; k++) begin
      id_wr_en = 1; id_wr_addr = 6'(k); id_wr_data = 8'(k + 1);
      tick();
    end
    id_wr_addr = 6'd50; id_wr_data = 8'hEE;
    tick();
    id_wr_en = 0;

    // Full scan: entries 1..45, wren on cycle 46, done on 47.
    for (int k = 0; k < 45; k++) push_idle(8'(k + 1), 1'b0, 1'b0);
    push_idle(8'h00, 1'b1, 1'b0);
    push_idle(8'h00, 1'b0, 1'b1);
    scan_start = 1;
    tick();
    scan_start = 0;
    check("scan_busy", 16'(busy), 16'h1);
    id_wr_en = 1; id_wr_addr = 6'd0; id_wr_data = 8'h77;
    tick();
    id_wr_en = 0;
    repeat (45) tick();
    check("scan_done_idle", 16'(busy), 16'h0);
    tick();

    // Back-to-back stream of four words.
    wd = '{8'h11, 8'h22, 8'h33, 8'h44};
    stream_start = 1; stream_len = 16'd4;
    tick();
    stream_start = 0;
    for (int k = 0; k < 4; k++) begin
      check("stream_ready", 16'(in_ready), 16'h1);
      in_valid = 1; in_data = wd[k]; in_tag_x = 8'd2; in_tag_y = 8'd0;
      push_word(wd[k], 8'd2, 8'd0, k == 3);
      tick();
    end
    in_valid = 0;
    check("stream_end_ready", 16'(in_ready), 16'h0);
    tick();

    // Gaps: valid pattern 1,0,0,1,1 with len 3.
    gap_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    gap_d = '{8'h5A, 8'hA5, 8'h3C};
    gap_x = '{8'd3, 8'd4, 8'd5};
    gap_y = '{8'd1, 8'd2, 8'd0};
    stream_start = 1; stream_len = 16'd3;
    tick();
    stream_start = 0;
    gi = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = gap_v[k];
      if (gap_v[k]) begin
        in_data = gap_d[gi]; in_tag_x = gap_x[gi]; in_tag_y = gap_y[gi];
        push_word(gap_d[gi], gap_x[gi], gap_y[gi], gi == 2);
        gi++;
      end else begin
        in_data = 8'hC3; in_tag_x = 8'd9; in_tag_y = 8'd9;
      end
      tick();
    end
    in_valid = 0;
`ifdef MCN_TX_STALL_CNT_EN
    exp_stall = 16'd2;
`else
    exp_stall = 16'd0;
`endif
    check("gap_stall_cnt", stall_cnt, exp_stall);
    check("gap_end_busy", 16'(busy), 16'h0);
    tick();

    // Zero-length stream: done only, no state change.
    push_idle(8'h00, 1'b0, 1'b1);
    stream_start = 1; stream_len = 16'd0;
    tick();
    stream_start = 0;
    check("len0_busy", 16'(busy), 16'h0);
    tick();

    // Collision: scan wins; table[0] still 1 since the write during scan was dropped.
    for (int k = 0; k < 45; k++) push_idle(8'(k + 1), 1'b0, 1'b0);
    push_idle(8'h00, 1'b1, 1'b0);
    push_idle(8'h00, 1'b0, 1'b1);
    scan_start = 1; stream_start = 1; stream_len = 16'd5;
    in_valid = 1; in_data = 8'h99; in_tag_x = 8'd1; in_tag_y = 8'd1;
    tick();
    scan_start = 0; stream_start = 0;
    for (int k = 0; k < 47; k++) begin
      check("collision_ready", 16'(in_ready), 16'h0);
      tick();
    end
    in_valid = 0;
    check("collision_idle", 16'(busy), 16'h0);

    // Reset in the middle of a scan: values 1..21 appear, then nothing.
    for (int k = 0; k < 21; k++) push_idle(8'(k + 1), 1'b0, 1'b0);
    scan_start = 1;
    tick();
    scan_start = 0;
    repeat (20) tick();
    @(negedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("midrst_busy", 16'(busy), 16'h0);
    check("midrst_tag_x", 16'(tag_x), 16'h00FF);
    check("midrst_wren", 16'(id_wren), 16'h0);
    repeat (3) tick();
    nrst = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (id_wren) check("midrst_no_wren", 16'(id_wren), 16'h0);
      tick();
    end
    check("post_rst_busy", 16'(busy), 16'h0);

    check("queue_empty", 16'(q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
